// File: rtl/smoldvi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_pkg
// Purpose : Shared types and constants for the smoldvi link controller.
//           Holds the link FSM state encoding, the widest supported
//           clk_bit/clk_pix ratio and the width of the bit-phase counter.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package smoldvi_pkg;

  // Largest clk_bit cycles per clk_pix cycle the phase counter can hold
  localparam int DIV_MAX = 8;
  localparam int PHASE_W = 3;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_CLK_RUN   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_DRAIN     = 2'd3
  } link_state_t;

endpackage
`default_nettype wire

// File: rtl/smoldvi_sync.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_sync
// Purpose : STAGES-deep flop chain that brings an asynchronous level into
//           the clk domain. All flops reset to 0, so the output reads 0
//           until the input has been stable high for STAGES edges.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset
//           d     - asynchronous input level
//           q     - synchronized output level
// Rev     : 1.0 - initial release
// ============================================================================
module smoldvi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES <= 1) begin : g_single
      logic ff;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= 1'b0;
        else        ff <= d;
      end
      assign q = ff;
    end else begin : g_chain
      logic [STAGES-1:0] ff;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
      end
      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/smoldvi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_link_ctrl
// Purpose : DVI link sequencer in the clk_bit domain. Divides clk_bit into a
//           phase-aligned clk_pix, issues the per-character serializer load
//           strobe, orders the pixel-domain reset release and gates the
//           serializer output around PLL lock and the software enable.
// Ports   : clk_bit       - bit clock from the PLL
//           rst_n_bit     - asynchronous active-low reset
//           pll_lock      - PLL lock (asynchronous)
//           en            - link enable (asynchronous)
//           clk_pix       - divided pixel clock, registered
//           phase         - bit-phase counter 0..DIV-1
//           load          - one-cycle serializer reload strobe
//           rst_n_pix_req - pixel-domain reset request (active-low)
//           ser_oe        - serializer output enable
//           link_active   - high while the link is ACTIVE
//           lock_lost     - sticky loss-of-lock flag, cleared by reset only
// Rev     : 1.0 - initial release
// ============================================================================
module smoldvi_link_ctrl
  import smoldvi_pkg::*;
#(
  parameter int DIV         = 5,
  parameter int WARMUP      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_bit,
  input  logic               rst_n_bit,
  input  logic               pll_lock,
  input  logic               en,
  output logic               clk_pix,
  output logic [PHASE_W-1:0] phase,
  output logic               load,
  output logic               rst_n_pix_req,
  output logic               ser_oe,
  output logic               link_active,
  output logic               lock_lost
);

  // Clamp keeps the phase terminal value representable in PHASE_W bits
  localparam int DIV_USE = (DIV > DIV_MAX) ? DIV_MAX : DIV;
  localparam int WCNT_W  = $clog2(WARMUP) + 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DIV_USE - 1);
  localparam logic [PHASE_W:0]   CLK_HIGH   = (PHASE_W + 1)'((DIV_USE + 1) / 2);
  localparam logic [WCNT_W-1:0]  WCNT_LAST  = WCNT_W'(WARMUP - 1);

  logic               lock_s;
  logic               en_s;
  link_state_t        state;
  logic [WCNT_W-1:0]  wcnt;
  logic               phase_last;
  logic [PHASE_W-1:0] phase_nx;
  logic               clk_nx;

  smoldvi_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk_bit),
    .rst_n (rst_n_bit),
    .d     (pll_lock),
    .q     (lock_s)
  );

  smoldvi_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk   (clk_bit),
    .rst_n (rst_n_bit),
    .d     (en),
    .q     (en_s)
  );

  assign phase_last = (phase == PHASE_LAST);
  assign phase_nx   = phase_last ? '0 : phase + 1'b1;
  // clk_pix is registered from the upcoming phase so its rising edge lines
  // up with phase 0 and the high time is ceil(DIV/2) bit cycles.
  assign clk_nx     = ({1'b0, phase_nx} < CLK_HIGH);

  always_ff @(posedge clk_bit or negedge rst_n_bit) begin
    if (!rst_n_bit) begin
      state         <= ST_WAIT_LOCK;
      phase         <= '0;
      clk_pix       <= 1'b0;
      load          <= 1'b0;
      rst_n_pix_req <= 1'b0;
      ser_oe        <= 1'b0;
      link_active   <= 1'b0;
      lock_lost     <= 1'b0;
      wcnt          <= '0;
    end else if (state != ST_WAIT_LOCK && !lock_s) begin
      // Loss of lock overrides every other transition
      state         <= ST_WAIT_LOCK;
      phase         <= '0;
      clk_pix       <= 1'b0;
      load          <= 1'b0;
      rst_n_pix_req <= 1'b0;
      ser_oe        <= 1'b0;
      link_active   <= 1'b0;
      lock_lost     <= 1'b1;
      wcnt          <= '0;
    end else if (state == ST_WAIT_LOCK) begin
      phase   <= '0;
      wcnt    <= '0;
      // Phase 0 always falls in the high half, so clk_pix rises on entry
      clk_pix <= lock_s;
      if (lock_s) state <= ST_CLK_RUN;
    end else begin
      phase   <= phase_nx;
      clk_pix <= clk_nx;
      // Exits from ACTIVE/DRAIN to CLK_RUN only happen at phase wrap, so
      // the current state is enough to qualify the strobe.
      load    <= (phase_nx == PHASE_LAST) &&
                 (state == ST_ACTIVE || state == ST_DRAIN);
      case (state)
        ST_CLK_RUN: begin
          if (phase_last) begin
            if (wcnt != WCNT_LAST) begin
              wcnt <= wcnt + 1'b1;
            end else if (en_s) begin
              state         <= ST_ACTIVE;
              wcnt          <= '0;
              rst_n_pix_req <= 1'b1;
              ser_oe        <= 1'b1;
              link_active   <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (!en_s) begin
            state       <= ST_DRAIN;
            link_active <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Finish the character in flight before shutting the output off
          if (phase_last) begin
            state         <= ST_CLK_RUN;
            wcnt          <= '0;
            rst_n_pix_req <= 1'b0;
            ser_oe        <= 1'b0;
          end
        end
        default: begin
          state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smoldvi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_smoldvi_link_ctrl
// Purpose : Directed self-checking bench for smoldvi_link_ctrl. Main
//           instance DIV=5 / WARMUP=4; two extra instances at DIV=2 and
//           DIV=8 exercise the divider extremes.
// Ports   : none
// Rev     : 1.0 - initial release
// ============================================================================
module tb_smoldvi_link_ctrl;

  logic clk_bit   = 1'b0;
  logic rst_n_bit = 1'b0;
  logic pll_lock  = 1'b0;
  logic en        = 1'b1;
  logic lock2     = 1'b0;
  logic en_hi     = 1'b1;

  logic       clk_pix, load, rst_n_pix_req, ser_oe, link_active, lock_lost;
  logic [2:0] phase;
  logic       d2_clk, d2_load, d2_rq, d2_oe, d2_act, d2_lost;
  logic [2:0] d2_phase;
  logic       d8_clk, d8_load, d8_rq, d8_oe, d8_act, d8_lost;
  logic [2:0] d8_phase;

  int total = 0;
  int bad   = 0;

  always #5 clk_bit = ~clk_bit;

  smoldvi_link_ctrl #(.DIV(5), .WARMUP(4), .SYNC_STAGES(2)) dut (
    .clk_bit(clk_bit), .rst_n_bit(rst_n_bit), .pll_lock(pll_lock), .en(en),
    .clk_pix(clk_pix), .phase(phase), .load(load), .rst_n_pix_req(rst_n_pix_req),
    .ser_oe(ser_oe), .link_active(link_active), .lock_lost(lock_lost)
  );

  smoldvi_link_ctrl #(.DIV(2), .WARMUP(1), .SYNC_STAGES(2)) dut_d2 (
    .clk_bit(clk_bit), .rst_n_bit(rst_n_bit), .pll_lock(lock2), .en(en_hi),
    .clk_pix(d2_clk), .phase(d2_phase), .load(d2_load), .rst_n_pix_req(d2_rq),
    .ser_oe(d2_oe), .link_active(d2_act), .lock_lost(d2_lost)
  );

  smoldvi_link_ctrl #(.DIV(8), .WARMUP(1), .SYNC_STAGES(2)) dut_d8 (
    .clk_bit(clk_bit), .rst_n_bit(rst_n_bit), .pll_lock(lock2), .en(en_hi),
    .clk_pix(d8_clk), .phase(d8_phase), .load(d8_load), .rst_n_pix_req(d8_rq),
    .ser_oe(d8_oe), .link_active(d8_act), .lock_lost(d8_lost)
  );

  // {clk_pix, phase[2:0], load, rst_n_pix_req, ser_oe, link_active, lock_lost}
  logic [8:0] outs;
  assign outs = {clk_pix, phase, load, rst_n_pix_req, ser_oe, link_active, lock_lost};

  function automatic logic [8:0] ev(input logic ck, input int ph, input logic ld,
                                    input logic rq, input logic oe, input logic act,
                                    input logic lost);
    logic [2:0] p;
    p = ph[2:0];
    return {ck, p, ld, rq, oe, act, lost};
  endfunction

  task automatic tick();
    @(posedge clk_bit);
    #1;
  endtask

  task automatic test_reset();
    rst_n_bit = 1'b0;
    pll_lock  = 1'b0;
    en        = 1'b1;
    lock2     = 1'b0;
    repeat (3) tick();
    total++;
    if (outs !== 9'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", outs, 9'h000);
    end
    rst_n_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (outs !== 9'h000) begin
        bad++;
        $display("FAIL wait_lock_idle i=%0d got=%h want=%h", i, outs, 9'h000);
      end
    end
  endtask

  task automatic test_startup();
    logic [8:0] e;
    int ph;
    logic act;
    pll_lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outs !== 9'h000) begin
        bad++;
        $display("FAIL startup_sync_delay i=%0d got=%h want=%h", i, outs, 9'h000);
      end
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      ph  = k % 5;
      act = (k >= 20);
      e   = ev(ph < 3, ph, act && (ph == 4), act, act, act, 1'b0);
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL startup k=%0d got=%h want=%h", k, outs, e);
      end
    end
  endtask

  task automatic test_drain();
    logic [8:0] e [6];
    e[0] = ev(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[1] = ev(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[2] = ev(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[3] = ev(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[4] = ev(1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    e[5] = ev(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL drain step=%0d got=%h want=%h", i, outs, e[i]);
      end
      if (i == 1) en = 1'b0;
    end
  endtask

  task automatic test_en_low();
    logic [8:0] e;
    int ph;
    logic act;
    for (int i = 1; i <= 30; i++) begin
      tick();
      ph = i % 5;
      e  = ev(ph < 3, ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL en_low_hold i=%0d got=%h want=%h", i, outs, e);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      ph  = i % 5;
      act = (i == 5);
      e   = ev(ph < 3, ph, 1'b0, act, act, act, 1'b0);
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL en_rise_activate i=%0d got=%h want=%h", i, outs, e);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [8:0] e [9];
    int ph;
    logic act;
    logic [8:0] w;
    e[0] = ev(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[1] = ev(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[2] = ev(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e[3] = ev(1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 4; i < 9; i++) e[i] = ev(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL lock_loss step=%0d got=%h want=%h", i, outs, e[i]);
      end
      if (i == 1) pll_lock = 1'b0;
      if (i == 6) pll_lock = 1'b1;
    end
    for (int k = 0; k <= 20; k++) begin
      tick();
      ph  = k % 5;
      act = (k >= 20);
      w   = ev(ph < 3, ph, 1'b0, act, act, act, 1'b1);
      total++;
      if (outs !== w) begin
        bad++;
        $display("FAIL relock_warmup k=%0d got=%h want=%h", k, outs, w);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [8:0] e [3];
    e[0] = ev(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    e[1] = ev(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    e[2] = ev(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL pre_reset_drain step=%0d got=%h want=%h", i, outs, e[i]);
      end
    end
    #2 rst_n_bit = 1'b0;
    #1;
    total++;
    if (outs !== 9'h000) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", outs, 9'h000);
    end
    tick();
    total++;
    if (outs !== 9'h000) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", outs, 9'h000);
    end
    rst_n_bit = 1'b1;
  endtask

  task automatic sample_div(input int div, output logic ck, output logic [2:0] ph,
                            output logic ld, output logic act);
    if (div == 2) begin
      ck = d2_clk; ph = d2_phase; ld = d2_load; act = d2_act;
    end else begin
      ck = d8_clk; ph = d8_phase; ld = d8_load; act = d8_act;
    end
  endtask

  task automatic test_div(input int div);
    logic ck, ld, act, prev;
    logic [2:0] ph, jj;
    logic [4:0] got, want;
    bit found;
    int half;
    half  = (div + 1) / 2;
    found = 1'b0;
    sample_div(div, prev, ph, ld, act);
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      sample_div(div, ck, ph, ld, act);
      if (ck && !prev) found = 1'b1;
      prev = ck;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL div%0d_rise got=no_rising_edge want=rising_edge_within_20", div);
    end
    for (int j = 0; j < 2 * div; j++) begin
      if (j > 0) begin
        tick();
        sample_div(div, ck, ph, ld, act);
      end
      jj   = 3'(j % div);
      want = {((j % div) < half), jj, ((j % div) == div - 1), 1'b1};
      got  = {ck, ph, ld, act};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL div%0d_pattern j=%0d got=%b want=%b", div, j, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_drain();
    test_en_low();
    test_lock_loss();
    test_reset_mid_drain();
    lock2 = 1'b1;
    repeat (40) tick();
    test_div(2);
    test_div(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
